// File: rtl/hmmm_cpu_if.sv
// Host-side handshake for the HMMM core: program-load strobes from the host,
// and I/O qualifiers plus the halt flag from the core. The shared data bus is
// tristated, so it is a plain inout port on the core rather than a member here.
interface hmmm_cpu_if;
  logic pgrm_addr;
  logic pgrm_data;
  logic read;
  logic write;
  logic halt;

  modport master (
    output pgrm_addr, pgrm_data,
    input  read, write, halt
  );

  modport slave (
    input  pgrm_addr, pgrm_data,
    output read, write, halt
  );
endinterface

// File: rtl/hmmm_cpu.sv
// Harvey Mudd Miniature Machine core: 16 x 16-bit registers, a unified
// program/data memory with combinational reads, and a two-cycle
// FETCH/EXEC sequence per instruction. The host loads memory over the shared
// bus using two strobes; loading always takes priority over execution.
module hmmm_cpu #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  hmmm_cpu_if.slave  hif,
  inout  wire [15:0] bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_SYS    = 4'h0,
    OP_SETN   = 4'h1,
    OP_LOADN  = 4'h2,
    OP_STOREN = 4'h3,
    OP_REGMEM = 4'h4,
    OP_ADDN   = 4'h5,
    OP_ADD    = 4'h6,
    OP_SUB    = 4'h7,
    OP_MUL    = 4'h8,
    OP_DIV    = 4'h9,
    OP_MOD    = 4'hA,
    OP_JUMPN  = 4'hB,
    OP_JEQZN  = 4'hC,
    OP_JNEZN  = 4'hD,
    OP_JGTZN  = 4'hE,
    OP_JLTZN  = 4'hF
  } op_t;

  state_t      state, state_next;
  logic [7:0]  pc, load_addr;
  logic [15:0] ir;
  logic [15:0] regs [16];
  logic [15:0] mem  [MEM_DEPTH];

  // Instruction fields.
  op_t         op;
  logic [3:0]  x_idx, y_idx, z_idx;
  logic [7:0]  n8;
  logic [15:0] sext_n;

  assign op     = op_t'(ir[15:12]);
  assign x_idx  = ir[11:8];
  assign y_idx  = ir[7:4];
  assign z_idx  = ir[3:0];
  assign n8     = ir[7:0];
  assign sext_n = {{8{n8[7]}}, n8};

  // Register operands; r0 is hard-wired to zero on the read side.
  logic [15:0] rx, ry, rz, ry_dec, ry_inc;
  logic [15:0] prod;
  logic signed [15:0] quot, rem;
  logic [7:0]  pc_inc;

  assign rx     = (x_idx == 4'd0) ? 16'h0000 : regs[x_idx];
  assign ry     = (y_idx == 4'd0) ? 16'h0000 : regs[y_idx];
  assign rz     = (z_idx == 4'd0) ? 16'h0000 : regs[z_idx];
  assign ry_dec = ry - 16'd1;
  assign ry_inc = ry + 16'd1;
  assign prod   = ry * rz;
  assign quot   = $signed(ry) / $signed(rz);
  assign rem    = $signed(ry) % $signed(rz);
  assign pc_inc = pc + 8'd1;

  // Core advances only when neither reset nor a host strobe is active.
  logic host_busy, run, exec_en;
  assign host_busy = hif.pgrm_addr | hif.pgrm_data;
  assign run       = !host_busy && !rst;
  assign exec_en   = run && (state == S_EXEC);

  // Effects of the instruction held in IR, applied at the end of EXEC.
  logic [7:0]  pc_next;
  logic        rx_we, ry_we, mem_we, do_halt, do_read, do_write;
  logic [15:0] rx_wdata, ry_wdata, mem_wdata;
  logic [7:0]  mem_waddr;

  // Instruction decode and execute datapath.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    pc_next   = pc_inc;
    rx_we     = 1'b0;
    rx_wdata  = 16'h0000;
    ry_we     = 1'b0;
    ry_wdata  = 16'h0000;
    mem_we    = 1'b0;
    mem_waddr = n8;
    mem_wdata = rx;
    do_halt   = 1'b0;
    do_read   = 1'b0;
    do_write  = 1'b0;

    unique case (op)
      OP_SYS: begin
        if (y_idx == 4'd0) begin
          case (z_idx)
            4'd0: do_halt = (x_idx == 4'd0);
            4'd1: begin
              do_read  = 1'b1;
              rx_we    = 1'b1;
              rx_wdata = bus;
            end
            4'd2: do_write = 1'b1;
            4'd3: pc_next  = rx[7:0];
            default: ;
          endcase
        end
      end
      OP_SETN: begin
        rx_we    = 1'b1;
        rx_wdata = sext_n;
      end
      OP_LOADN: begin
        rx_we    = 1'b1;
        rx_wdata = mem[n8];
      end
      OP_STOREN: mem_we = 1'b1;
      OP_REGMEM: begin
        case (z_idx)
          4'd0: begin
            rx_we    = 1'b1;
            rx_wdata = mem[ry[7:0]];
          end
          4'd1: begin
            mem_we    = 1'b1;
            mem_waddr = ry[7:0];
          end
          4'd2: begin
            ry_we    = 1'b1;
            ry_wdata = ry_dec;
            rx_we    = 1'b1;
            rx_wdata = mem[ry_dec[7:0]];
          end
          4'd3: begin
            mem_we    = 1'b1;
            mem_waddr = ry[7:0];
            ry_we     = 1'b1;
            ry_wdata  = ry_inc;
          end
          default: ;
        endcase
      end
      OP_ADDN: begin
        rx_we    = 1'b1;
        rx_wdata = rx + sext_n;
      end
      OP_ADD: begin
        rx_we    = 1'b1;
        rx_wdata = ry + rz;
      end
      OP_SUB: begin
        rx_we    = 1'b1;
        rx_wdata = ry - rz;
      end
      OP_MUL: begin
        rx_we    = 1'b1;
        rx_wdata = prod;
      end
      OP_DIV: begin
        rx_we    = 1'b1;
        rx_wdata = (rz == 16'h0000) ? 16'h0000 : quot;
      end
      OP_MOD: begin
        rx_we    = 1'b1;
        rx_wdata = (rz == 16'h0000) ? 16'h0000 : rem;
      end
      OP_JUMPN: begin
        pc_next = n8;
        if (x_idx != 4'd0) begin
          rx_we    = 1'b1;
          rx_wdata = {8'h00, pc_inc};
        end
      end
      OP_JEQZN: if (rx == 16'h0000)  pc_next = n8;
      OP_JNEZN: if (rx != 16'h0000)  pc_next = n8;
      OP_JGTZN: if ($signed(rx) > 0) pc_next = n8;
      OP_JLTZN: if (rx[15])          pc_next = n8;
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // FSM next state and bus qualifiers.
  logic read_o, write_o;
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    case (state)
      S_FETCH: if (run) state_next = S_EXEC;
      S_EXEC: begin
        if (run) begin
          state_next = do_halt ? S_HALT : S_FETCH;
          read_o     = do_read;
          write_o    = do_write;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  assign hif.read  = read_o;
  assign hif.write = write_o;
  assign hif.halt  = (state == S_HALT);
  assign bus       = write_o ? rx : 16'hzzzz;

  // PC, IR, load address and register file updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= 8'h00;
      ir        <= 16'h0000;
      load_addr <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else begin
      if (hif.pgrm_addr) load_addr <= bus[7:0];
      if (run && state == S_FETCH) ir <= mem[pc];
      if (exec_en) begin
        if (!do_halt) pc <= pc_next;
        // rY is written first so rX wins if both name the same register.
        if (ry_we && y_idx != 4'd0) regs[y_idx] <= ry_wdata;
        if (rx_we && x_idx != 4'd0) regs[x_idx] <= rx_wdata;
      end
    end
  end

  // Unified memory write port: host load first, then store instructions.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset so a loaded program
    // survives rst; only the write enable is gated by it.
    if (!rst) begin
      if (hif.pgrm_data)          mem[load_addr] <= bus;
      else if (exec_en && mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_hmmm_cpu.sv
// Self-checking bench for hmmm_cpu: directed programs with known outputs plus
// random straight-line programs, all compared against an instruction-level
// reference interpreter that shares the memory image with the host loader.
module tb_hmmm_cpu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hmmm_cpu_if hif ();
  wire  [15:0] bus;
  logic        host_oe;
  logic [15:0] host_val;
  assign bus = host_oe ? host_val : 16'hzzzz;

  hmmm_cpu #(.MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] prog_q[$];
  logic [15:0] in_q[$];
  logic [15:0] spec_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          exp_steps, exp_reads, dut_reads;
  bit          exp_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All host tasks start and end just after a falling edge.
  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    host_oe       = 1'b1;
    host_val      = {8'h00, a};
    hif.pgrm_addr = 1'b1;
    @(negedge clk);
    hif.pgrm_addr = 1'b0;
    hif.pgrm_data = 1'b1;
    host_val      = d;
    @(negedge clk);
    hif.pgrm_data = 1'b0;
    host_oe       = 1'b0;
    ref_mem[a]    = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Instruction-level interpreter: runs from PC 0 with cleared registers.
  task automatic model_run();
    logic [15:0] r [16];
    logic [15:0] ins[$];
    logic [15:0] w, v;
    logic [3:0]  op, x, y, z;
    logic [7:0]  n;
    int pc, nxt, sn, a, b, ad;
    ins = in_q;
    exp_q.delete();
    exp_steps = 0;
    exp_reads = 0;
    exp_halt  = 0;
    pc = 0;
    for (int i = 0; i < 16; i++) r[i] = 16'h0;
    while (!exp_halt && exp_steps < 1000) begin
      w  = ref_mem[pc];
      op = w[15:12]; x = w[11:8]; y = w[7:4]; z = w[3:0]; n = w[7:0];
      sn = int'($signed(n));
      a  = int'($signed(r[y]));
      b  = int'($signed(r[z]));
      nxt = (pc + 1) % 256;
      exp_steps++;
      case (op)
        4'h0: begin
          if (w == 16'h0) exp_halt = 1;
          else if (y == 0 && z == 1) begin
            exp_reads++;
            if (ins.size() > 0) r[x] = ins.pop_front();
            else                r[x] = 16'h0;
          end
          else if (y == 0 && z == 2) exp_q.push_back(r[x]);
          else if (y == 0 && z == 3) nxt = int'(r[x]) & 255;
        end
        4'h1: r[x] = 16'(sn);
        4'h2: r[x] = ref_mem[n];
        4'h3: ref_mem[n] = r[x];
        4'h4: begin
          case (z)
            4'd0: r[x] = ref_mem[int'(r[y]) & 255];
            4'd1: ref_mem[int'(r[y]) & 255] = r[x];
            4'd2: begin
              ad = (int'(r[y]) - 1) & 255;
              v = ref_mem[ad];
              r[y] = r[y] - 16'd1;
              r[x] = v;
            end
            4'd3: begin
              ref_mem[int'(r[y]) & 255] = r[x];
              r[y] = r[y] + 16'd1;
            end
            default: ;
          endcase
        end
        4'h5: r[x] = 16'(int'($signed(r[x])) + sn);
        4'h6: r[x] = 16'(a + b);
        4'h7: r[x] = 16'(a - b);
        4'h8: r[x] = 16'(a * b);
        4'h9: r[x] = (b == 0) ? 16'h0 : 16'(a / b);
        4'hA: r[x] = (b == 0) ? 16'h0 : 16'(a % b);
        4'hB: begin
          if (x != 0) r[x] = 16'((pc + 1) % 256);
          nxt = int'(n);
        end
        4'hC: if (r[x] == 0) nxt = int'(n);
        4'hD: if (r[x] != 0) nxt = int'(n);
        4'hE: if (int'($signed(r[x])) > 0) nxt = int'(n);
        4'hF: if (int'($signed(r[x])) < 0) nxt = int'(n);
        default: ;
      endcase
      r[0] = 16'h0;
      if (!exp_halt) pc = nxt;
    end
  endtask

  // Clock the DUT until halt (bounded), serving reads and capturing writes.
  task automatic run_dut(output int cyc, output bit halted);
    logic [15:0] dq[$];
    dq = in_q;
    cyc = 0;
    halted = 0;
    dut_reads = 0;
    obs_q.delete();
    while (!halted && cyc < 3000) begin
      host_oe = 1'b0;
      if (hif.read) begin
        dut_reads++;
        if (dq.size() > 0) host_val = dq.pop_front();
        else               host_val = 16'h0;
        host_oe = 1'b1;
      end
      if (hif.write) obs_q.push_back(bus);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      halted = hif.halt;
    end
    host_oe = 1'b0;
  endtask

  task automatic exec_compare(input string name);
    int cyc;
    bit halted;
    model_run();
    run_dut(cyc, halted);
    check({name, "_halt"}, 32'(halted), 32'd1);
    check({name, "_cycles"}, cyc, 2 * exp_steps);
    check({name, "_reads"}, dut_reads, exp_reads);
    check({name, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_out%0d", name, i), obs_q[i], exp_q[i]);
    for (int i = 0; i < spec_q.size(); i++)
      check($sformatf("%s_spec%0d", name, i),
            (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF, spec_q[i]);
    repeat (3) @(negedge clk);
    check({name, "_sticky"}, {hif.halt, hif.read, hif.write}, 3'b100);
  endtask

  task automatic run_case(input string name);
    for (int i = 0; i < prog_q.size(); i++) load_word(8'(i), prog_q[i]);
    do_reset();
    exec_compare(name);
  endtask

  // Random straight-line program with forward-only conditional jumps,
  // followed by a dump of every register and a halt.
  task automatic gen_random_prog();
    int body, kind, tgt;
    logic [3:0] x, y, z;
    logic [7:0] n;
    body = 20;
    prog_q.delete();
    in_q.delete();
    spec_q.delete();
    for (int i = 0; i < body; i++) begin
      kind = $urandom_range(0, 11);
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      z = 4'($urandom_range(0, 15));
      n = 8'($urandom_range(0, 255));
      case (kind)
        0, 1: prog_q.push_back({4'h1, x, n});
        2:    prog_q.push_back({4'h5, x, n});
        3, 4, 5: prog_q.push_back({4'($urandom_range(6, 10)), x, y, z});
        6:    prog_q.push_back({4'h2, x, n});
        7:    prog_q.push_back({4'h3, x, 8'h80 | n});
        8: begin
          prog_q.push_back({4'h0, x, 8'h01});
          in_q.push_back(16'($urandom()));
        end
        9:    prog_q.push_back({4'h0, x, 8'h02});
        10: begin
          tgt = $urandom_range(i + 1, body);
          prog_q.push_back({4'($urandom_range(12, 15)), x, 8'(tgt)});
        end
        default: prog_q.push_back({4'h4, x, y, 4'h9});
      endcase
    end
    for (int r = 0; r < 16; r++) prog_q.push_back({4'h0, 4'(r), 8'h02});
    prog_q.push_back(16'h0000);
  endtask

  initial begin
    host_oe       = 1'b0;
    host_val      = 16'h0;
    hif.pgrm_addr = 1'b0;
    hif.pgrm_data = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    do_reset();
    check("reset_outputs", {hif.halt, hif.read, hif.write}, 3'b000);

    for (int a = 0; a < 256; a++) load_word(8'(a), 16'($urandom()));

    prog_q = '{16'h0101, 16'h1402, 16'hA214, 16'hD206, 16'h6311,
               16'hB008, 16'h1501, 16'h6315, 16'h0302, 16'h0000};
    in_q = '{16'd6};  spec_q = '{16'd12};
    run_case("even");
    in_q = '{16'd7};  spec_q = '{16'd8};
    run_case("odd");

    // Reset mid-run: halt clears, the program restarts from PC 0.
    check("pre_rst_halt", 32'(hif.halt), 32'd1);
    do_reset();
    check("post_rst", {hif.halt, hif.read, hif.write}, 3'b000);
    repeat (5) @(negedge clk);
    do_reset();
    check("mid_rst_halt", 32'(hif.halt), 32'd0);
    in_q = '{16'd6};  spec_q = '{16'd12};
    exec_compare("midrst");

    // Host writes while halted still land in memory and leave halt set.
    load_word(8'hF0, 16'h1234);
    check("load_while_halted", {hif.halt, hif.read, hif.write}, 3'b100);
    prog_q = '{16'h27F0, 16'h0702, 16'h0000};
    in_q.delete();  spec_q = '{16'h1234};
    run_case("halted_load");

    prog_q = '{16'h11FB, 16'h1203, 16'h9312, 16'hA412, 16'h0302,
               16'h0402, 16'h9510, 16'h0502, 16'h0000};
    spec_q = '{16'hFFFF, 16'hFFFE, 16'h0000};
    run_case("divmod");

    prog_q = '{16'h1120, 16'h1255, 16'h4213, 16'h4312, 16'h0302,
               16'h0102, 16'h2620, 16'h0602, 16'h0000};
    spec_q = '{16'h0055, 16'h0020, 16'h0055};
    run_case("stack");

    prog_q = '{16'h1109, 16'hBE06, 16'h0102, 16'h0002, 16'h0E02,
               16'h0000, 16'h5101, 16'h1007, 16'h6011, 16'h0E03};
    spec_q = '{16'h000A, 16'h0000, 16'h0002};
    run_case("call");

    for (int t = 0; t < 12; t++) begin
      gen_random_prog();
      run_case($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hmmm_cpu.md
Name: hmmm_cpu

Overview:
- 16-bit Harvey Mudd Miniature Machine (HMMM) processor core with 16 registers, 256x16 unified program/data memory, and a single shared bidirectional 16-bit bus.
- The bus is used for program loading and for the read/write I/O instructions.
- An external host loads the program through the bus, pulses reset, and the core runs until it executes halt.

Parameters:
- MEM_DEPTH, 256, words of unified memory; address width is 8 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pgrm_addr  in  1  host strobe: latch bus into load-address register.
- pgrm_data  in  1  host strobe: write bus into mem[load address].
- read  out  1  core is executing read; host must drive bus this cycle.
- write  out  1  core is executing write; core drives bus this cycle.
- bus  inout  16  shared data bus; core drives only while write=1, else Z.
- halt  out  1  core has executed halt; sticky until rst.

Behaviour:
- Reset (rst high at a clock edge): PC=0, state=FETCH, r1..r15=0, IR=0, load address=0, halt=0.
- Reset does NOT clear memory, so a loaded program survives reset.
- read and write are 0 in the reset state.
- Host loading has priority over execution:
  - pgrm_addr=1 at an edge: load address <= bus[7:0].
  - pgrm_data=1 at an edge: mem[load address] <= bus.
  - While either strobe is high, the core does not advance state/PC and read/write are 0.
- Two-state FSM per instruction:
  - FETCH: IR <= mem[PC], go to EXEC.
  - EXEC: execute IR; PC <= PC+1 unless a jump is taken; go to FETCH.
  - One instruction takes 2 cycles. Memory reads are combinational (asynchronous).
- Register rules: r0 always reads 0 and writes to it are discarded.
- Arithmetic:
  - 16-bit two's complement; results truncated to 16 bits.
  - n8 immediates are sign-extended for setn/addn and zero-extended as addresses.
  - PC and addresses are 8 bits and wrap at 255->0.
- Encodings (fields: op[15:12] X[11:8] Y[7:4] Z[3:0], n=[7:0]); every state change below takes effect at the end of EXEC:
  - 0000 0000 0000 0000 halt: halt<=1, core stops (stays in a HALT state) until rst.
  - 0000 X 0000 0001 read: read=1 during EXEC; rX <= bus sampled at the end of EXEC.
  - 0000 X 0000 0010 write: write=1 during EXEC; bus=rX.
  - 0000 X 0000 0011 jumpr: PC <= rX[7:0].
  - 0001 setn: rX <= sext(n).
  - 0010 loadn: rX <= mem[n].
  - 0011 storen: mem[n] <= rX.
  - 0100 X Y 0000 loadr: rX <= mem[rY].
  - 0100 X Y 0001 storer: mem[rY] <= rX.
  - 0100 X Y 0010 popr: rY <= rY-1; rX <= mem[rY-1].
  - 0100 X Y 0011 pushr: mem[rY] <= rX; rY <= rY+1.
  - 0101 addn: rX <= rX + sext(n).
  - 0110 add: rX <= rY+rZ.
  - 0111 sub: rX <= rY-rZ.
  - 1000 mul: rX <= low 16 bits of rY*rZ.
  - 1001 div: rX <= signed rY/rZ, truncating toward zero.
  - 1010 mod: rX <= signed rY%rZ, result takes the sign of rY.
  - Divisor 0 gives result 0 for both div and mod.
  - 1011 0000 n jumpn: PC<=n.
  - 1011 X n calln (X!=0): rX<=PC+1, PC<=n.
  - 1100 jeqzn: PC<=n if rX==0.
  - 1101 jnezn: PC<=n if rX!=0.
  - 1110 jgtzn: PC<=n if rX>0 (signed).
  - 1111 jltzn: PC<=n if rX<0 (signed).
- Any other encoding executes as a no-op (PC+1).
- Once halted:
  - read=write=0, bus=Z, PC frozen.
  - Program strobes still write memory.
- rst mid-instruction abandons the instruction; no register or memory write occurs on that edge.

Test Plan:
- Load the 10-word program [0x0101, 0x1402, 0xA214, 0xD206, 0x6311, 0xB008, 0x1501, 0x6315, 0x0302, 0x0000], reset, hold bus=6 -> read pulses once, write pulses once with bus=12, then halt=1 stays high.
- Same program, host drives bus=7 -> write outputs bus=8 (7+1 via the jnezn path), then halt.
- Run setn r1 -5, setn r2 3, div r3 r1 r2, mod r4 r1 r2, write r3, write r4 -> bus shows 0xFFFF (-1) then 0xFFFE (-2). Then div r5 r1 r0 -> r5=0.
- Run setn r1 0x20, setn r2 0x55, pushr r2 r1, popr r3 r1, write r3 -> bus shows 0x0055; write r1 shows 0x0020; mem[0x20]=0x0055.
- Run calln r14 to a subroutine containing jumpr r14 -> execution returns to caller+1. Writing to r0 leaves r0=0.
- Assert rst mid-run after a program has been loaded -> PC restarts at 0, the program still executes correctly, and halt clears.
